// File: rtl/and_bitwise_unit.sv
// ============================================================================
// and_bitwise_unit : bitwise AND of two operands with zero/ones/popcount flags,
//                    combinational or one-cycle registered outputs.
// Revision 1.0
// ============================================================================
`default_nettype none

module and_bitwise_unit #(
   parameter int WIDTH           = 32,
   parameter int REGISTER_OUTPUT = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_valid,
   input  logic [WIDTH-1:0]           i_1,
   input  logic [WIDTH-1:0]           i_2,
   output logic [WIDTH-1:0]           o,
   output logic                       o_zero,
   output logic                       o_ones,
   output logic [$clog2(WIDTH+1)-1:0] o_count,
   output logic                       o_valid
);

   localparam int CW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] w_and;
   logic             w_zero;
   logic             w_ones;
   logic [CW-1:0]    w_count;

   assign w_and  = i_1 & i_2;
   assign w_zero = ~|w_and;
   assign w_ones = &w_and;

   always_comb begin
      w_count = '0;
      for (int k = 0; k < WIDTH; k++) begin
         w_count = w_count + CW'(w_and[k]);
      end
   end

   generate
      if (REGISTER_OUTPUT != 0) begin : g_reg
         logic [WIDTH-1:0] r_o;
         logic             r_zero;
         logic             r_ones;
         logic [CW-1:0]    r_count;
         logic             r_valid;

         // Reset value keeps the flags consistent with a zero result.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_o     <= '0;
               r_zero  <= 1'b1;
               r_ones  <= 1'b0;
               r_count <= '0;
               r_valid <= 1'b0;
            end else begin
               r_o     <= w_and;
               r_zero  <= w_zero;
               r_ones  <= w_ones;
               r_count <= w_count;
               r_valid <= i_valid;
            end
         end

         assign o       = r_o;
         assign o_zero  = r_zero;
         assign o_ones  = r_ones;
         assign o_count = r_count;
         assign o_valid = r_valid;
      end else begin : g_comb
         logic w_unused;
         assign w_unused = &{1'b0, clk, rst};

         assign o       = w_and;
         assign o_zero  = w_zero;
         assign o_ones  = w_ones;
         assign o_count = w_count;
         assign o_valid = i_valid;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_and_bitwise_unit.sv
// ============================================================================
// tb_and_bitwise_unit : checks combinational, registered and WIDTH=1 builds
//                       against a behavioural model of the AND unit.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_and_bitwise_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [31:0] i_1, i_2;

   logic [31:0] c_o, r_o;
   logic        c_zero, c_ones, c_valid, r_zero, r_ones, r_valid;
   logic [5:0]  c_count, r_count;

   logic        n_o, n_zero, n_ones, n_count, n_valid;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   and_bitwise_unit #(.WIDTH(32), .REGISTER_OUTPUT(0)) u_comb (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_1(i_1), .i_2(i_2),
      .o(c_o), .o_zero(c_zero), .o_ones(c_ones), .o_count(c_count), .o_valid(c_valid)
   );

   and_bitwise_unit #(.WIDTH(32), .REGISTER_OUTPUT(1)) u_reg (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_1(i_1), .i_2(i_2),
      .o(r_o), .o_zero(r_zero), .o_ones(r_ones), .o_count(r_count), .o_valid(r_valid)
   );

   and_bitwise_unit #(.WIDTH(1), .REGISTER_OUTPUT(0)) u_narrow (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_1(i_1[0:0]), .i_2(i_2[0:0]),
      .o(n_o), .o_zero(n_zero), .o_ones(n_ones), .o_count(n_count), .o_valid(n_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Behavioural reference: result, flags and count from plain arithmetic.
   task automatic model(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output logic on,
                        output logic [31:0] cnt);
      res = 32'h0;
      cnt = 0;
      for (int k = 0; k < 32; k++) begin
         if (a[k] == 1'b1 && b[k] == 1'b1) begin
            res = res + (32'h1 << k);
            cnt = cnt + 1;
         end
      end
      z  = (cnt == 0);
      on = (cnt == 32);
   endtask

   task automatic step(input logic [31:0] a, input logic [31:0] b, input logic v);
      logic [31:0] e_o, e_cnt;
      logic        e_z, e_on;
      @(negedge clk);
      i_1 = a; i_2 = b; i_valid = v;
      model(a, b, e_o, e_z, e_on, e_cnt);
      #1;
      chk("comb_o",     c_o,            e_o);
      chk("comb_zero",  {31'h0, c_zero}, {31'h0, e_z});
      chk("comb_ones",  {31'h0, c_ones}, {31'h0, e_on});
      chk("comb_count", {26'h0, c_count}, e_cnt);
      chk("comb_valid", {31'h0, c_valid}, {31'h0, v});
      chk("w1_o",     {31'h0, n_o},     {31'h0, a[0] & b[0]});
      chk("w1_zero",  {31'h0, n_zero},  {31'h0, ~(a[0] & b[0])});
      chk("w1_ones",  {31'h0, n_ones},  {31'h0, a[0] & b[0]});
      chk("w1_count", {31'h0, n_count}, {31'h0, a[0] & b[0]});
      @(posedge clk);
      #1;
      chk("reg_o",     r_o,             e_o);
      chk("reg_zero",  {31'h0, r_zero},  {31'h0, e_z});
      chk("reg_ones",  {31'h0, r_ones},  {31'h0, e_on});
      chk("reg_count", {26'h0, r_count}, e_cnt);
      chk("reg_valid", {31'h0, r_valid}, {31'h0, v});
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_o"},     r_o,               32'h0);
      chk({tag, "_zero"},  {31'h0, r_zero},   32'h1);
      chk({tag, "_ones"},  {31'h0, r_ones},   32'h0);
      chk({tag, "_count"}, {26'h0, r_count},  32'h0);
      chk({tag, "_valid"}, {31'h0, r_valid},  32'h0);
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b1; i_1 = 32'hFFFF_FFFF; i_2 = 32'hFFFF_FFFF;
      #2;
      chk_reset("reset");
      @(negedge clk);
      rst = 1'b0;

      step(32'h0000_129F, 32'h0000_0BD2, 1'b1);
      step(32'hFFFF_FFFF, 32'hA849_2525, 1'b1);
      step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      step(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      step(32'hFF8F_E94B, 32'hFFFC_4A3F, 1'b1);
      step(32'h0000_0001, 32'h8000_0001, 1'b0);

      for (int n = 0; n < 24; n++) begin
         step($urandom, $urandom | ((n % 3 == 0) ? $urandom : 32'h0), 1'($urandom));
      end

      // Asynchronous reset between edges while a valid result is held.
      step(32'hDEAD_BEEF, 32'hF0F0_FFFF, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("midrst");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset("postrst");

      step(32'hE800_1900, 32'hFFFF_FFFF, 1'b1);
      step(32'h1234_5678, 32'hFFFF_0000, 1'b0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

`default_nettype wire
